// File: rtl/width_change_pkg.sv
// -----------------------------------------------------------------------------
// width_change_pkg
//   Shared helpers for the 8<->16 packer/unpacker pair.
//   - DEF_AWIDTH / DEF_BWIDTH : default wide / narrow widths used by both blocks
//   - cnt_max(a, b)           : number of narrow slices per wide word
//   - cnt_w(a, b)             : width of the slice index counter
//   - slice_off(...)          : bit offset of slice <idx> inside the wide word
// -----------------------------------------------------------------------------
package width_change_pkg;

   localparam int unsigned DEF_AWIDTH = 16;
   localparam int unsigned DEF_BWIDTH = 8;

   function automatic int unsigned cnt_max(input int unsigned aw, input int unsigned bw);
      return aw / bw;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned aw, input int unsigned bw);
      int unsigned n;
      n = aw / bw;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Offset of the lowest bit of slice <idx>. MSB-first walks down from the top slice.
   function automatic int unsigned slice_off(input int unsigned aw, input int unsigned bw,
                                             input int unsigned idx, input bit lsb_first);
      if (lsb_first)
         return idx * bw;
      else
         return aw - bw * (idx + 1);
   endfunction

endpackage

// File: rtl/width_change_16to8.sv
// -----------------------------------------------------------------------------
// width_change_16to8
//   Unpacker: splits each AWIDTH-bit input word into AWIDTH/BWIDTH slices, one
//   per accepted output beat. Full valid/ready on both sides, no loss under
//   backpressure, no bubble between consecutive words.
//   Ports:
//     clk    in          clock, all logic on posedge
//     rst    in          synchronous reset, active-high
//     a_vld  in          input word valid
//     a_rdy  out         input ready (combinational from b_rdy)
//     a      in  AWIDTH  input word
//     b_vld  out         output slice valid (registered)
//     b_rdy  in          downstream ready
//     b      out BWIDTH  output slice (combinational slice of held word)
//   Configuration:
//     WIDTH_CHANGE_16TO8_LSB_FIRST_EN defined -> LSB slice emitted first;
//     undefined -> MSB slice first (matches the packer fill order).
// -----------------------------------------------------------------------------
module width_change_16to8
   import width_change_pkg::*;
#(
   parameter int unsigned AWIDTH = DEF_AWIDTH,
   parameter int unsigned BWIDTH = DEF_BWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_vld,
   output logic              a_rdy,
   input  logic [AWIDTH-1:0] a,
   output logic              b_vld,
   input  logic              b_rdy,
   output logic [BWIDTH-1:0] b
);

   localparam int unsigned CNT_MAX = cnt_max(AWIDTH, BWIDTH);
   localparam int unsigned CNT_W   = cnt_w(AWIDTH, BWIDTH);

`ifdef WIDTH_CHANGE_16TO8_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   logic [AWIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              b_vld_q, b_vld_d;

   logic              last;
   logic              accept;
   logic              beat;
   logic [AWIDTH-1:0] shifted;

   assign last   = (cnt_q == CNT_W'(CNT_MAX - 1));
   // Ready while empty, or while the final slice leaves this cycle, so a new
   // word can reload with no idle cycle in between.
   assign a_rdy  = !b_vld_q || (b_rdy && last);
   assign accept = a_vld && a_rdy;
   assign beat   = b_vld_q && b_rdy;

   always_comb begin
      data_d  = data_q;
      cnt_d   = cnt_q;
      b_vld_d = b_vld_q;
      if (accept) begin
         // Takes priority over a simultaneous last beat.
         data_d  = a;
         cnt_d   = '0;
         b_vld_d = 1'b1;
      end else if (beat) begin
         if (last) begin
            cnt_d   = '0;
            b_vld_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         cnt_q   <= '0;
         b_vld_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         b_vld_q <= b_vld_d;
      end
   end

   // Shift instead of an indexed part-select keeps the index width-agnostic.
   assign shifted = data_q >> slice_off(AWIDTH, BWIDTH, 32'(cnt_q), LSB_FIRST);
   assign b       = shifted[BWIDTH-1:0];
   assign b_vld   = b_vld_q;

endmodule

// File: tb/tb_width_change_16to8.sv
module tb_width_change_16to8;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_vld;
   logic        a_rdy;
   logic [15:0] a;
   logic        b_vld;
   logic        b_rdy;
   logic [7:0]  b;

   int checks = 0;
   int errors = 0;

`ifdef WIDTH_CHANGE_16TO8_LSB_FIRST_EN
   localparam bit LSBF = 1'b1;
`else
   localparam bit LSBF = 1'b0;
`endif

   always #5 clk = ~clk;

   width_change_16to8 #(.AWIDTH(16), .BWIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .a_vld (a_vld),
      .a_rdy (a_rdy),
      .a     (a),
      .b_vld (b_vld),
      .b_rdy (b_rdy),
      .b     (b)
   );

   // Expected i-th emitted byte of a word.
   function automatic logic [7:0] sl(input logic [15:0] w, input int i);
      int idx;
      idx = LSBF ? i : 1 - i;
      return w[idx*8 +: 8];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      #1;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] q[$];
   logic [7:0]  got0;
   int          nbytes;
   int          sent;
   int          rcvd;
   int          cyc;
   logic        acc, bt;
   logic [15:0] w, exp_w;

   initial begin
      rst = 1'b1; a_vld = 1'b1; a = 16'hFFFF; b_rdy = 1'b1;

      // 1. reset held two cycles with a_vld asserted
      tick();
      chk("rst1_bvld", b_vld, 0); chk("rst1_b", b, 8'h00); chk("rst1_ardy", a_rdy, 1);
      tick();
      chk("rst2_bvld", b_vld, 0); chk("rst2_b", b, 8'h00); chk("rst2_ardy", a_rdy, 1);
      rst = 1'b0; a_vld = 1'b0;
      tick();

      // 2. single word
      a = 16'hA55A; a_vld = 1'b1; b_rdy = 1'b1;
      chk("sw_ardy0", a_rdy, 1);
      tick(); a_vld = 1'b0;
      chk("sw_vld1", b_vld, 1); chk("sw_b1", b, sl(16'hA55A, 0)); chk("sw_ardy1", a_rdy, 0);
      tick();
      chk("sw_vld2", b_vld, 1); chk("sw_b2", b, sl(16'hA55A, 1)); chk("sw_ardy2", a_rdy, 1);
      tick();
      chk("sw_vld3", b_vld, 0);

      // 3. back-to-back, gap-free
      a = 16'h1122; a_vld = 1'b1;
      chk("bb_ardy0", a_rdy, 1);
      tick(); a = 16'h3344;
      chk("bb_b0", b, sl(16'h1122, 0)); chk("bb_ardy1", a_rdy, 0);
      tick();
      chk("bb_b1", b, sl(16'h1122, 1)); chk("bb_ardy2", a_rdy, 1);
      tick(); a_vld = 1'b0;
      chk("bb_vld2", b_vld, 1); chk("bb_b2", b, sl(16'h3344, 0)); chk("bb_ardy3", a_rdy, 0);
      tick();
      chk("bb_b3", b, sl(16'h3344, 1));
      tick();
      chk("bb_vld_end", b_vld, 0);

      // 4. backpressure after first slice
      a = 16'hBEEF; a_vld = 1'b1; b_rdy = 1'b1;
      tick(); a_vld = 1'b0; b_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_b", b, sl(16'hBEEF, 0)); chk("bp_hold_vld", b_vld, 1);
         chk("bp_hold_ardy", a_rdy, 0);
         tick();
      end
      b_rdy = 1'b1;
      chk("bp_rel_b0", b, sl(16'hBEEF, 0));
      tick();
      chk("bp_b1", b, sl(16'hBEEF, 1)); chk("bp_vld1", b_vld, 1);
      tick();
      chk("bp_vld_end", b_vld, 0);

      // 5. reset mid-word
      a = 16'hCAFE; a_vld = 1'b1;
      tick(); a_vld = 1'b0;
      chk("rm_b0", b, sl(16'hCAFE, 0));
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("rm_vld", b_vld, 0); chk("rm_b", b, 8'h00);
      a = 16'h0102; a_vld = 1'b1;
      tick(); a_vld = 1'b0;
      chk("rm_n0", b, sl(16'h0102, 0)); chk("rm_nv0", b_vld, 1);
      tick();
      chk("rm_n1", b, sl(16'h0102, 1));
      tick();
      chk("rm_vld_end", b_vld, 0);

      // 6. random handshakes, 1000 words, re-packed and compared in order
      sent = 0; rcvd = 0; nbytes = 0; cyc = 0;
      while (rcvd < 1000 && cyc < 20000) begin
         if (!a_vld && sent < 1000 && $urandom_range(0, 3) != 0) begin
            a_vld = 1'b1;
            a = 16'($urandom);
         end
         b_rdy = ($urandom_range(0, 3) != 0);
         #1;
         acc = a_vld && a_rdy;
         bt  = b_vld && b_rdy;
         if (acc) begin
            q.push_back(a);
            sent++;
         end
         if (bt) begin
            if (nbytes == 0) begin
               got0 = b;
               nbytes = 1;
            end else begin
               w = LSBF ? {b, got0} : {got0, b};
               exp_w = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
               nbytes = 0;
               rcvd++;
               chk("rand_word", w, exp_w);
            end
         end
         tick();
         cyc++;
         if (acc) a_vld = 1'b0;
      end
      chk("rand_count", rcvd, 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
